// File: rtl/gemac_tx_framer.sv
// gemac_tx_framer: drains length-prefixed frames from the TX FIFO and emits GMII
// preamble, SFD, payload, zero pad and inter-frame gap.
module gemac_tx_framer #(
    parameter int MIN_LEN = 60,
    parameter int MAX_LEN = 1514,
    parameter int IFG_LEN = 12
) (
    input  logic       TX_CLK,
    input  logic       RST,
    output logic       FIFO_RD_ENA,
    input  logic [7:0] FIFO_RD_DATA,
    input  logic       FIFO_RD_EMPTY,
    output logic [7:0] GMII_TXD,
    output logic       GMII_TX_EN,
    output logic       GMII_TX_ER,
    output logic       BUSY,
    output logic       FRAME_DONE,
    output logic       ERR_UNDERRUN,
    output logic       ERR_LENGTH
);
    localparam logic [15:0] MIN_L = 16'(MIN_LEN);
    localparam logic [15:0] MAX_L = 16'(MAX_LEN);
    localparam logic [15:0] IFG_L = 16'(IFG_LEN);
    typedef enum logic [3:0] {IDLE, LEN_HI, LEN_LO, PREAMBLE, SFD, DATA, PAD, DISCARD, IFG} state_t;
    state_t      st;
    logic [15:0] len, rem, cnt, len_in;
    logic [7:0]  len_hi;
    always_comb begin
        len_in = {len_hi, FIFO_RD_DATA};
        FIFO_RD_ENA = RST && !FIFO_RD_EMPTY &&
                      (st == LEN_HI || st == LEN_LO || st == DATA || (st == DISCARD && rem != 16'd0));
        BUSY = st != IDLE;
    end
    // Outputs are registered from the current state, so each state's symbol
    // appears on GMII one cycle later; this keeps TX_EN contiguous from 0x55 to the last byte.
    always_ff @(posedge TX_CLK or negedge RST) begin
        if (!RST) begin
            st           <= IDLE;
            len          <= 16'd0;
            len_hi       <= 8'd0;
            rem          <= 16'd0;
            cnt          <= 16'd0;
            GMII_TXD     <= 8'h00;
            GMII_TX_EN   <= 1'b0;
            GMII_TX_ER   <= 1'b0;
            FRAME_DONE   <= 1'b0;
            ERR_UNDERRUN <= 1'b0;
            ERR_LENGTH   <= 1'b0;
        end else begin
            GMII_TXD     <= 8'h00;
            GMII_TX_EN   <= 1'b0;
            GMII_TX_ER   <= 1'b0;
            FRAME_DONE   <= 1'b0;
            ERR_UNDERRUN <= 1'b0;
            ERR_LENGTH   <= 1'b0;
            case (st)
                IDLE: if (!FIFO_RD_EMPTY) st <= LEN_HI;
                LEN_HI: if (FIFO_RD_ENA) begin
                    len_hi <= FIFO_RD_DATA;
                    st     <= LEN_LO;
                end
                LEN_LO: if (FIFO_RD_ENA) begin
                    len        <= len_in;
                    rem        <= len_in;
                    cnt        <= 16'd6;
                    ERR_LENGTH <= len_in > MAX_L;
                    st         <= len_in > MAX_L ? DISCARD : PREAMBLE;
                end
                PREAMBLE: begin
                    GMII_TX_EN <= 1'b1;
                    GMII_TXD   <= 8'h55;
                    cnt        <= cnt - 16'd1;
                    if (cnt == 16'd0) st <= SFD;
                end
                SFD: begin
                    GMII_TX_EN <= 1'b1;
                    GMII_TXD   <= 8'hD5;
                    cnt        <= MIN_L - 16'd1;
                    st         <= rem == 16'd0 ? PAD : DATA;
                end
                DATA: if (FIFO_RD_ENA) begin
                    GMII_TX_EN <= 1'b1;
                    GMII_TXD   <= FIFO_RD_DATA;
                    rem        <= rem - 16'd1;
                    if (rem == 16'd1) begin
                        st         <= len < MIN_L ? PAD : IFG;
                        cnt        <= len < MIN_L ? MIN_L - len - 16'd1 : IFG_L - 16'd1;
                        FRAME_DONE <= len >= MIN_L;
                    end
                end else begin
                    GMII_TX_EN   <= 1'b1;
                    GMII_TX_ER   <= 1'b1;
                    ERR_UNDERRUN <= 1'b1;
                    st           <= DISCARD;
                end
                PAD: begin
                    GMII_TX_EN <= 1'b1;
                    cnt        <= cnt - 16'd1;
                    if (cnt == 16'd0) begin
                        st         <= IFG;
                        cnt        <= IFG_L - 16'd1;
                        FRAME_DONE <= 1'b1;
                    end
                end
                DISCARD: begin
                    if (FIFO_RD_ENA) rem <= rem - 16'd1;
                    if (rem == 16'd0 || (FIFO_RD_ENA && rem == 16'd1)) begin
                        st  <= IFG;
                        cnt <= IFG_L - 16'd1;
                    end
                end
                IFG: begin
                    cnt <= cnt - 16'd1;
                    if (cnt == 16'd0) st <= IDLE;
                end
                default: st <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_gemac_tx_framer.sv
// tb_gemac_tx_framer: FIFO model plus GMII scoreboard for the transmit framer.
module tb_gemac_tx_framer;
    logic       TX_CLK = 1'b0;
    logic       RST = 1'b0;
    logic       FIFO_RD_ENA;
    logic [7:0] FIFO_RD_DATA = 8'h00;
    logic       FIFO_RD_EMPTY = 1'b1;
    logic [7:0] GMII_TXD;
    logic       GMII_TX_EN, GMII_TX_ER, BUSY, FRAME_DONE, ERR_UNDERRUN, ERR_LENGTH;
    int         tests = 0, fails = 0;
    logic [7:0] fifo[$];
    logic [8:0] exp_q[$];
    logic [8:0] exp_v;
    bit         pop_flag = 1'b0;
    int         pops = 0, en_cyc = 0, done_cnt = 0, und_cnt = 0, len_cnt = 0;
    int         low_run = 0, last_gap = 0, ena_viol = 0;

    gemac_tx_framer dut (
        .TX_CLK(TX_CLK), .RST(RST), .FIFO_RD_ENA(FIFO_RD_ENA), .FIFO_RD_DATA(FIFO_RD_DATA),
        .FIFO_RD_EMPTY(FIFO_RD_EMPTY), .GMII_TXD(GMII_TXD), .GMII_TX_EN(GMII_TX_EN),
        .GMII_TX_ER(GMII_TX_ER), .BUSY(BUSY), .FRAME_DONE(FRAME_DONE),
        .ERR_UNDERRUN(ERR_UNDERRUN), .ERR_LENGTH(ERR_LENGTH)
    );

    always #4 TX_CLK = ~TX_CLK;

    // FWFT FIFO model: the pop decided at a rising edge is applied at the following falling edge.
    always @(negedge TX_CLK) begin
        if (pop_flag && fifo.size() > 0) begin
            fifo.delete(0);
            pops++;
        end
        FIFO_RD_EMPTY = fifo.size() == 0;
        FIFO_RD_DATA = FIFO_RD_EMPTY ? 8'h00 : fifo[0];
        #1;
        pop_flag = FIFO_RD_ENA;
        if (FIFO_RD_ENA && FIFO_RD_EMPTY) ena_viol++;
    end

    always @(negedge TX_CLK) begin
        if (!RST) low_run = 0;
        else begin
            if (GMII_TX_EN) begin
                if (low_run > 0) last_gap = low_run;
                low_run = 0;
                en_cyc++;
                tests++;
                if (exp_q.size() == 0) begin
                    fails++;
                    $display("FAIL tx_extra got %h want none", {GMII_TX_ER, GMII_TXD});
                end else begin
                    exp_v = exp_q.pop_front();
                    if ({GMII_TX_ER, GMII_TXD} !== exp_v) begin
                        fails++;
                        $display("FAIL tx_stream got %h want %h", {GMII_TX_ER, GMII_TXD}, exp_v);
                    end
                end
            end else low_run++;
            if (FRAME_DONE) done_cnt++;
            if (ERR_UNDERRUN) und_cnt++;
            if (ERR_LENGTH) len_cnt++;
        end
    end

    task automatic push_frame(input int len, input int n, input logic [7:0] first);
        logic [15:0] l;
        l = 16'(len);
        fifo.push_back(l[15:8]);
        fifo.push_back(l[7:0]);
        for (int i = 0; i < n; i++) fifo.push_back(8'(first + i));
        if (len <= 1514) begin
            for (int i = 0; i < 7; i++) exp_q.push_back(9'h055);
            exp_q.push_back(9'h0D5);
            for (int i = 0; i < (n < len ? n : len); i++) exp_q.push_back({1'b0, 8'(first + i)});
            if (n < len) exp_q.push_back(9'h100);
            else for (int i = len; i < 60; i++) exp_q.push_back(9'h000);
        end
    endtask

    task automatic wait_quiet(input int budget, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < budget; i++) begin
            @(negedge TX_CLK);
            #2;
            if (fifo.size() == 0 && !BUSY && exp_q.size() == 0) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    task automatic test_reset;
        bit ok;
        int e0, d0;
        push_frame(64, 64, 8'h80);
        repeat (3) @(negedge TX_CLK);
        #2;
        tests++;
        if ({GMII_TX_EN, GMII_TX_ER, GMII_TXD, BUSY, FRAME_DONE, ERR_UNDERRUN, ERR_LENGTH, FIFO_RD_ENA} !== 15'd0) begin
            fails++;
            $display("FAIL reset_outputs got en=%b er=%b txd=%h busy=%b ena=%b want all 0",
                     GMII_TX_EN, GMII_TX_ER, GMII_TXD, BUSY, FIFO_RD_ENA);
        end
        e0 = en_cyc; d0 = done_cnt;
        @(posedge TX_CLK);
        #2 RST = 1'b1;
        wait_quiet(300, ok);
        tests++;
        if (!ok) begin fails++; $display("FAIL reset_first_frame timeout got busy=%b want idle", BUSY); end
        tests++;
        if (en_cyc - e0 !== 72) begin fails++; $display("FAIL reset_first_en got %0d want 72", en_cyc - e0); end
        tests++;
        if (done_cnt - d0 !== 1) begin fails++; $display("FAIL reset_first_done got %0d want 1", done_cnt - d0); end
    endtask

    task automatic test_reset_mid_frame;
        bit ok;
        int e0, d0;
        e0 = en_cyc;
        push_frame(100, 100, 8'h10);
        for (int i = 0; i < 300 && en_cyc - e0 < 38; i++) @(negedge TX_CLK);
        tests++;
        if (en_cyc - e0 < 38) begin fails++; $display("FAIL mid_reset_progress got %0d want >=38", en_cyc - e0); end
        @(posedge TX_CLK);
        #2 RST = 1'b0;
        #1;
        tests++;
        if ({GMII_TX_EN, GMII_TX_ER, GMII_TXD, BUSY, FIFO_RD_ENA} !== 12'd0) begin
            fails++;
            $display("FAIL mid_reset_outputs got en=%b er=%b txd=%h busy=%b ena=%b want all 0",
                     GMII_TX_EN, GMII_TX_ER, GMII_TXD, BUSY, FIFO_RD_ENA);
        end
        @(negedge TX_CLK);
        #2;
        fifo.delete();
        exp_q.delete();
        repeat (3) @(posedge TX_CLK);
        #2 RST = 1'b1;
        e0 = en_cyc; d0 = done_cnt;
        push_frame(64, 64, 8'hA0);
        wait_quiet(300, ok);
        tests++;
        if (!ok) begin fails++; $display("FAIL mid_reset_next timeout got busy=%b want idle", BUSY); end
        tests++;
        if (en_cyc - e0 !== 72) begin fails++; $display("FAIL mid_reset_next_en got %0d want 72", en_cyc - e0); end
        tests++;
        if (done_cnt - d0 !== 1) begin fails++; $display("FAIL mid_reset_next_done got %0d want 1", done_cnt - d0); end
    endtask

    task automatic test_min_frame;
        bit ok;
        int e0, d0;
        e0 = en_cyc; d0 = done_cnt;
        push_frame(64, 64, 8'h00);
        wait_quiet(300, ok);
        tests++;
        if (!ok) begin fails++; $display("FAIL min_frame timeout got busy=%b want idle", BUSY); end
        tests++;
        if (en_cyc - e0 !== 72) begin fails++; $display("FAIL min_frame_en got %0d want 72", en_cyc - e0); end
        tests++;
        if (done_cnt - d0 !== 1) begin fails++; $display("FAIL min_frame_done got %0d want 1", done_cnt - d0); end
        tests++;
        if (low_run !== 12) begin fails++; $display("FAIL min_frame_ifg got %0d want 12", low_run); end
    endtask

    task automatic test_pad;
        bit ok;
        int e0, d0;
        e0 = en_cyc; d0 = done_cnt;
        push_frame(5, 5, 8'h01);
        wait_quiet(300, ok);
        tests++;
        if (!ok) begin fails++; $display("FAIL pad timeout got busy=%b want idle", BUSY); end
        tests++;
        if (en_cyc - e0 !== 68) begin fails++; $display("FAIL pad_en got %0d want 68", en_cyc - e0); end
        tests++;
        if (done_cnt - d0 !== 1) begin fails++; $display("FAIL pad_done got %0d want 1", done_cnt - d0); end
        e0 = en_cyc;
        push_frame(0, 0, 8'h00);
        wait_quiet(300, ok);
        tests++;
        if (en_cyc - e0 !== 68 || !ok) begin fails++; $display("FAIL pad_zero_len got %0d want 68", en_cyc - e0); end
    endtask

    task automatic test_underrun;
        bit ok;
        int e0, d0, u0, p0;
        e0 = en_cyc; d0 = done_cnt; u0 = und_cnt; p0 = pops;
        push_frame(100, 40, 8'h20);
        for (int i = 0; i < 300 && und_cnt == u0; i++) begin
            @(negedge TX_CLK);
            #2;
        end
        tests++;
        if (und_cnt - u0 !== 1) begin fails++; $display("FAIL underrun_pulse got %0d want 1", und_cnt - u0); end
        tests++;
        if (exp_q.size() !== 0) begin fails++; $display("FAIL underrun_stream got %0d left want 0", exp_q.size()); end
        repeat (20) @(negedge TX_CLK);
        #2;
        tests++;
        if (BUSY !== 1'b1) begin fails++; $display("FAIL underrun_discard_wait got busy=%b want 1", BUSY); end
        for (int i = 0; i < 60; i++) fifo.push_back(8'(8'h48 + i));
        wait_quiet(300, ok);
        tests++;
        if (!ok) begin fails++; $display("FAIL underrun_discard timeout got busy=%b want idle", BUSY); end
        tests++;
        if (pops - p0 !== 102) begin fails++; $display("FAIL underrun_pops got %0d want 102", pops - p0); end
        tests++;
        if (en_cyc - e0 !== 49) begin fails++; $display("FAIL underrun_en got %0d want 49", en_cyc - e0); end
        tests++;
        if (done_cnt - d0 !== 0) begin fails++; $display("FAIL underrun_done got %0d want 0", done_cnt - d0); end
        e0 = en_cyc; d0 = done_cnt;
        push_frame(64, 64, 8'hC0);
        wait_quiet(300, ok);
        tests++;
        if (en_cyc - e0 !== 72 || done_cnt - d0 !== 1 || !ok) begin
            fails++;
            $display("FAIL underrun_next got en=%0d done=%0d want 72 1", en_cyc - e0, done_cnt - d0);
        end
    endtask

    task automatic test_length;
        bit ok;
        int e0, d0, l0, p0;
        e0 = en_cyc; d0 = done_cnt; l0 = len_cnt; p0 = pops;
        push_frame(16'h0700, 1792, 8'h00);
        wait_quiet(3000, ok);
        tests++;
        if (!ok) begin fails++; $display("FAIL length timeout got busy=%b want idle", BUSY); end
        tests++;
        if (len_cnt - l0 !== 1) begin fails++; $display("FAIL length_pulse got %0d want 1", len_cnt - l0); end
        tests++;
        if (en_cyc - e0 !== 0) begin fails++; $display("FAIL length_en got %0d want 0", en_cyc - e0); end
        tests++;
        if (pops - p0 !== 1794) begin fails++; $display("FAIL length_pops got %0d want 1794", pops - p0); end
        tests++;
        if (done_cnt - d0 !== 0) begin fails++; $display("FAIL length_done got %0d want 0", done_cnt - d0); end
        e0 = en_cyc; d0 = done_cnt;
        push_frame(64, 64, 8'h33);
        wait_quiet(300, ok);
        tests++;
        if (en_cyc - e0 !== 72 || done_cnt - d0 !== 1 || !ok) begin
            fails++;
            $display("FAIL length_next got en=%0d done=%0d want 72 1", en_cyc - e0, done_cnt - d0);
        end
    endtask

    task automatic test_back_to_back;
        bit ok;
        int e0, d0;
        e0 = en_cyc; d0 = done_cnt;
        push_frame(64, 64, 8'h40);
        push_frame(64, 64, 8'h90);
        wait_quiet(400, ok);
        tests++;
        if (!ok) begin fails++; $display("FAIL b2b timeout got busy=%b want idle", BUSY); end
        tests++;
        if (last_gap !== 15) begin fails++; $display("FAIL b2b_gap got %0d want 15", last_gap); end
        tests++;
        if (done_cnt - d0 !== 2) begin fails++; $display("FAIL b2b_done got %0d want 2", done_cnt - d0); end
        tests++;
        if (en_cyc - e0 !== 144) begin fails++; $display("FAIL b2b_en got %0d want 144", en_cyc - e0); end
    endtask

    task automatic test_invariants;
        tests++;
        if (ena_viol !== 0) begin fails++; $display("FAIL ena_when_empty got %0d want 0", ena_viol); end
    endtask

    initial begin
        test_reset;
        test_reset_mid_frame;
        test_min_frame;
        test_pad;
        test_underrun;
        test_length;
        test_back_to_back;
        test_invariants;
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL global_timeout got running want finished");
        $fatal(1, "timeout");
    end
endmodule
